// File: rtl/md5_block_padder.sv
// md5_block_padder: packs a byte stream into 512-bit MD5 blocks and applies
// standard MD5 padding (0x80 marker, zero fill, little-endian bit length).
// Each block is presented with first/final flags.
// Optional macro MD5_HEX_OUT_EN adds a digest-to-ASCII-hex serialiser,
// which emits 32 lowercase characters.
module md5_block_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_byte,
  input  logic         in_keep,
  input  logic         in_last,
  output logic         in_ready,
  output logic         blk_valid,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_final,
  input  logic         blk_ready,
  output logic         busy
`ifdef MD5_HEX_OUT_EN
  ,
  input  logic         dig_valid,
  input  logic [127:0] dig,
  output logic         dig_ready,
  output logic         hex_valid,
  output logic [7:0]   hex_char,
  input  logic         hex_ready
`endif
);

  typedef enum logic [1:0] {FILL, EMIT, EXTRA, EMIT_LAST} state_t;

  state_t           state;
  logic [5:0]       idx;
  logic [LEN_W-1:0] len;
  logic             first;
  logic             started;     // at least one message byte has been taken
  logic             pend_extra;  // a length-only block must follow this one
  logic             extra_mark;  // the length-only block also carries the 0x80 marker

  // Candidate block contents if the presented token were accepted now.
  logic [6:0]       cnt_c;
  logic [LEN_W-1:0] len_c;
  logic [511:0]     data_c;

  assign in_ready  = (state == FILL);
  assign blk_valid = (state == EMIT) || (state == EMIT_LAST);
  assign busy      = (state != FILL) || started;

  // Merge the incoming byte and, on the last token, the marker and length.
  always_comb begin
    len_c  = len + (in_keep ? LEN_W'(8) : '0);
    cnt_c  = {1'b0, idx} + {6'b0, in_keep};
    data_c = blk_data;
    if (in_keep) data_c[{idx, 3'b000} +: 8] = in_byte;
    if (in_last) begin
      if (cnt_c < 7'd64) data_c[{cnt_c[5:0], 3'b000} +: 8] = 8'h80;
      if (cnt_c <= 7'd55) data_c[511:448] = 64'(len_c);
    end
  end

  // Padder FSM: fill, emit, optional length-only block, final emit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      idx        <= '0;
      len        <= '0;
      first      <= 1'b1;
      started    <= 1'b0;
      pend_extra <= 1'b0;
      extra_mark <= 1'b0;
      blk_data   <= '0;
      blk_first  <= 1'b0;
      blk_final  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            if (in_last) begin
              blk_data  <= data_c;
              len       <= len_c;
              blk_first <= first;
              if (cnt_c <= 7'd55) begin
                state     <= EMIT_LAST;
                blk_final <= 1'b1;
              end else begin
                state      <= EMIT;
                blk_final  <= 1'b0;
                pend_extra <= 1'b1;
                extra_mark <= cnt_c[6];
              end
            end else if (in_keep) begin
              blk_data <= data_c;
              len      <= len_c;
              idx      <= idx + 6'd1;
              started  <= 1'b1;
              if (idx == 6'd63) begin
                state     <= EMIT;
                blk_first <= first;
                blk_final <= 1'b0;
              end
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            blk_data  <= '0;
            idx       <= '0;
            first     <= 1'b0;
            blk_first <= 1'b0;
            state     <= pend_extra ? EXTRA : FILL;
          end
        end
        EXTRA: begin
          blk_data   <= {64'(len), 440'b0, (extra_mark ? 8'h80 : 8'h00)};
          pend_extra <= 1'b0;
          blk_first  <= first;
          blk_final  <= 1'b1;
          state      <= EMIT_LAST;
        end
        default: begin
          if (blk_ready) begin
            blk_data  <= '0;
            idx       <= '0;
            len       <= '0;
            first     <= 1'b1;
            started   <= 1'b0;
            blk_first <= 1'b0;
            blk_final <= 1'b0;
            state     <= FILL;
          end
        end
      endcase
    end
  end

`ifdef MD5_HEX_OUT_EN
  logic [127:0] dig_q;
  logic [4:0]   hcnt;
  logic [7:0]   hbyte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  assign hbyte    = dig_q[{hcnt[4:1], 3'b000} +: 8];
  assign hex_char = hex_ascii(hcnt[0] ? hbyte[3:0] : hbyte[7:4]);

  // Digest capture and one-character-per-handshake serialisation.
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_q     <= '0;
      hcnt      <= '0;
      hex_valid <= 1'b0;
      dig_ready <= 1'b1;
    end else if (dig_valid && dig_ready) begin
      dig_q     <= dig;
      hcnt      <= '0;
      hex_valid <= 1'b1;
      dig_ready <= 1'b0;
    end else if (hex_valid && hex_ready) begin
      if (hcnt == 5'd31) begin
        hex_valid <= 1'b0;
        dig_ready <= 1'b1;
      end else begin
        hcnt <= hcnt + 5'd1;
      end
    end
  end
`endif

endmodule
